parking_management: RTL and testbench

Occupancy tracker for a mixed university/public car park. Counts cars entering and leaving on a per-cycle basis and keeps university and public occupancy separate. Reports parked-car counts and remaining free spaces. Enforces a time-of-day capacity split driven by an internal hour counter. Sits behind the gate sensors and feeds the display/gate-control logic.

---
 rtl/parking_management.sv | 97 +++++++++
 tb/tb_parking_management.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/parking_management.sv
// Car park occupancy tracker: separate university/public counts, free-space reporting and an
// hour-of-day driven university capacity split.
module parking_management #(
    parameter int unsigned TOTAL_CAPACITY    = 700,
    parameter int unsigned UNI_CAPACITY_BASE = 500,
    parameter int unsigned CYCLES_PER_HOUR   = 3600,
    parameter int unsigned START_HOUR        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_entered,
    input  logic       is_uni_car_entered,
    input  logic       car_exited,
    input  logic       is_uni_car_exited,
    output logic [9:0] uni_parked_car,
    output logic [9:0] total_parked_car,
    output logic [9:0] uni_vacated_space,
    output logic [9:0] total_vacated_space
);

    localparam int unsigned CycW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
    localparam logic [CycW-1:0] CycLast   = CycW'(CYCLES_PER_HOUR - 1);
    localparam logic [9:0]      TotalCap  = 10'(TOTAL_CAPACITY);
    localparam logic [9:0]      UniBase   = 10'(UNI_CAPACITY_BASE);
    localparam logic [4:0]      HourReset = 5'(START_HOUR);

    logic [9:0]      uni_cnt_q, uni_cnt_d;
    logic [9:0]      pub_cnt_q, pub_cnt_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [4:0]      hour_q, hour_d;

    logic [9:0] uni_cap, pub_cap, total;
    logic [9:0] uni_after_exit, pub_after_exit, total_after_exit;
    logic       uni_dec, pub_dec, uni_inc, pub_inc;

    always_comb begin
        if (hour_q < 5'd13) begin
            uni_cap = UniBase;
        end else if (hour_q == 5'd13) begin
            uni_cap = 10'd450;
        end else if (hour_q == 5'd14) begin
            uni_cap = 10'd400;
        end else if (hour_q == 5'd15) begin
            uni_cap = 10'd350;
        end else begin
            uni_cap = 10'd200;
        end
    end

    assign pub_cap = TotalCap - uni_cap;
    assign total   = uni_cnt_q + pub_cnt_q;

    always_comb begin
        cyc_d  = cyc_q + CycW'(1);
        hour_d = hour_q;
        if (cyc_q == CycLast) begin
            cyc_d  = '0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    // Exits are applied first so a space freed this cycle is available to an entry.
    always_comb begin
        uni_dec          = car_exited && is_uni_car_exited && (uni_cnt_q != '0);
        pub_dec          = car_exited && !is_uni_car_exited && (pub_cnt_q != '0);
        uni_after_exit   = uni_cnt_q - {9'd0, uni_dec};
        pub_after_exit   = pub_cnt_q - {9'd0, pub_dec};
        total_after_exit = uni_after_exit + pub_after_exit;
        uni_inc          = car_entered && is_uni_car_entered &&
                           (uni_after_exit < uni_cap) && (total_after_exit < TotalCap);
        pub_inc          = car_entered && !is_uni_car_entered &&
                           (pub_after_exit < pub_cap) && (total_after_exit < TotalCap);
        uni_cnt_d        = uni_after_exit + {9'd0, uni_inc};
        pub_cnt_d        = pub_after_exit + {9'd0, pub_inc};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uni_cnt_q <= '0;
            pub_cnt_q <= '0;
            cyc_q     <= '0;
            hour_q    <= HourReset;
        end else begin
            uni_cnt_q <= uni_cnt_d;
            pub_cnt_q <= pub_cnt_d;
            cyc_q     <= cyc_d;
            hour_q    <= hour_d;
        end
    end

    // Capacity can drop below the current count; free space then saturates at zero.
    assign uni_parked_car      = uni_cnt_q;
    assign total_parked_car    = total;
    assign uni_vacated_space   = (uni_cnt_q >= uni_cap) ? 10'd0 : uni_cap - uni_cnt_q;
    assign total_vacated_space = TotalCap - total;

endmodule

// File: tb/tb_parking_management.sv
// Directed bench for parking_management: expected outputs queued with each stimulus step
// and compared after the clock edge that consumes it.
module tb_parking_management;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_m, ce_m, cu_m, xe_m, xu_m;
    logic       rst_s, ce_s, cu_s, xe_s, xu_s;
    logic [9:0] u_m, t_m, uv_m, tv_m;
    logic [9:0] u_s, t_s, uv_s, tv_s;

    parking_management #(
        .TOTAL_CAPACITY   (700),
        .UNI_CAPACITY_BASE(500),
        .CYCLES_PER_HOUR  (100000),
        .START_HOUR       (8)
    ) u_main (
        .clk                (clk),
        .reset              (rst_m),
        .car_entered        (ce_m),
        .is_uni_car_entered (cu_m),
        .car_exited         (xe_m),
        .is_uni_car_exited  (xu_m),
        .uni_parked_car     (u_m),
        .total_parked_car   (t_m),
        .uni_vacated_space  (uv_m),
        .total_vacated_space(tv_m)
    );

    parking_management #(
        .TOTAL_CAPACITY   (700),
        .UNI_CAPACITY_BASE(500),
        .CYCLES_PER_HOUR  (200),
        .START_HOUR       (8)
    ) u_sch (
        .clk                (clk),
        .reset              (rst_s),
        .car_entered        (ce_s),
        .is_uni_car_entered (cu_s),
        .car_exited         (xe_s),
        .is_uni_car_exited  (xu_s),
        .uni_parked_car     (u_s),
        .total_parked_car   (t_s),
        .uni_vacated_space  (uv_s),
        .total_vacated_space(tv_s)
    );

    typedef struct {
        string      tag;
        bit         sch;
        logic [9:0] u, t, uv, tv;
    } exp_t;

    exp_t sb_q[$];
    int   total_checks = 0;
    int   bad = 0;

    task automatic push_exp(input string tag, input bit sch, input int u, input int t,
                            input int uv, input int tv);
        exp_t e;
        e.tag = tag; e.sch = sch;
        e.u = 10'(u); e.t = 10'(t); e.uv = 10'(uv); e.tv = 10'(tv);
        sb_q.push_back(e);
    endtask

    task automatic check_front();
        exp_t       e;
        logic [9:0] ou, ot, ouv, otv;
        total_checks++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: observed no entry required one entry");
            return;
        end
        e = sb_q.pop_front();
        if (e.sch) begin
            ou = u_s; ot = t_s; ouv = uv_s; otv = tv_s;
        end else begin
            ou = u_m; ot = t_m; ouv = uv_m; otv = tv_m;
        end
        assert ({ou, ot, ouv, otv} === {e.u, e.t, e.uv, e.tv}) else begin
            bad++;
            $error("FAIL %s: observed %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", e.tag,
                   ou, ot, ouv, otv, e.u, e.t, e.uv, e.tv);
        end
    endtask

    task automatic drive(input bit sch, input logic ce, input logic cu, input logic xe,
                         input logic xu);
        if (sch) begin
            ce_s = ce; cu_s = cu; xe_s = xe; xu_s = xu;
            ce_m = 1'b0; cu_m = 1'b0; xe_m = 1'b0; xu_m = 1'b0;
        end else begin
            ce_m = ce; cu_m = cu; xe_m = xe; xu_m = xu;
            ce_s = 1'b0; cu_s = 1'b0; xe_s = 1'b0; xu_s = 1'b0;
        end
    endtask

    task automatic step(input bit sch, input logic ce, input logic cu, input logic xe,
                        input logic xu);
        drive(sch, ce, cu, xe, xu);
        @(posedge clk);
        #1;
    endtask

    task automatic stepx(input string tag, input bit sch, input logic ce, input logic cu,
                         input logic xe, input logic xu, input int u, input int t,
                         input int uv, input int tv);
        push_exp(tag, sch, u, t, uv, tv);
        step(sch, ce, cu, xe, xu);
        check_front();
    endtask

    task automatic check_now(input string tag, input bit sch, input int u, input int t,
                             input int uv, input int tv);
        push_exp(tag, sch, u, t, uv, tv);
        #1;
        check_front();
    endtask

    initial begin
        rst_m = 1'b0;
        rst_s = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now("reset_state", 1'b0, 0, 0, 500, 700);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_m = 1'b1;

        // Qualifiers are don't-care while strobes are low.
        stepx("idle0", 1'b0, 1'b0, 1'($urandom), 1'b0, 1'($urandom), 0, 0, 500, 700);
        stepx("idle1", 1'b0, 1'b0, 1'($urandom), 1'b0, 1'($urandom), 0, 0, 500, 700);

        stepx("uni_entry",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 499, 699);
        stepx("pub_entry",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 499, 698);
        stepx("uni_exit",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 500, 699);
        stepx("pub_exit",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 500, 700);

        for (int i = 1; i <= 4; i++)
            stepx($sformatf("burst_in%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                  i, i, 500 - i, 700 - i);
        for (int i = 1; i <= 5; i++)
            stepx($sformatf("burst_out%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  (i > 4) ? 0 : 4 - i, (i > 4) ? 0 : 4 - i,
                  (i > 4) ? 500 : 496 + i, (i > 4) ? 700 : 696 + i);

        for (int i = 0; i < 499; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        stepx("uni_full",      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 500, 500, 0, 200);
        stepx("uni_refused",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 500, 500, 0, 200);
        for (int i = 0; i < 199; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepx("total_full",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 500, 700, 0, 0);
        stepx("pub_refused",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 500, 700, 0, 0);
        stepx("pub_swap_full", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 500, 700, 0, 0);
        // Uni exit frees total space, but the public class is at its own cap.
        stepx("uni_out_pub_in", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 499, 699, 1, 1);

        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_m = 1'b0;
        check_now("async_reset", 1'b0, 0, 0, 500, 700);
        @(negedge clk);
        rst_m = 1'b1;
        stepx("after_reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 499, 699);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Schedule instance: 200 cycles per hour, edge n lands in hour 8 + n/200.
        @(negedge clk);
        rst_s = 1'b1;
        for (int i = 0; i < 299; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        stepx("sch_300", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 300, 300, 200, 400);
        for (int i = 0; i < 698; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepx("hour12", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 300, 200, 400);
        stepx("hour13", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 300, 150, 400);
        for (int i = 0; i < 199; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepx("hour14", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 300, 100, 400);
        for (int i = 0; i < 199; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepx("hour15", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 300, 50, 400);
        for (int i = 0; i < 199; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepx("hour16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 300, 0, 400);
        stepx("hour16_uni_refused", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 300, 300, 0, 400);
        for (int i = 0; i < 199; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        stepx("sch_swap", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 100, 300, 100, 400);
        for (int i = 0; i < 349; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stepx("pub_cap_500", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 100, 600, 100, 100);
        stepx("hour16_uni_ok", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 101, 601, 99, 99);

        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

endmodule
